// File: rtl/sdram_evt_pkg.sv
// Shared definitions for the SDRAM event scheduler: FSM state encoding, event geometry
// and address-field widths.
package sdram_evt_pkg;

  localparam int unsigned BURST_WORDS = 256;  // words per event (half a row)
  localparam int unsigned BANK_W      = 2;
  localparam int unsigned ROW_W       = 13;
  localparam int unsigned COL_W       = 9;
  localparam int unsigned EVT_W       = 16;   // event index {bank, row, slot}
  localparam int unsigned EVT_CNT_W   = 17;   // 0..65536 stored events
  localparam int unsigned LVL_W       = 10;   // FIFO level / space width
  localparam int unsigned WCNT_W      = 10;   // ack counter, saturating
  localparam int unsigned TMO_W       = 10;
  localparam int unsigned TIMEOUT     = 1023; // req cycles before giving up

  localparam logic [EVT_CNT_W-1:0] EVT_MAX = 17'h10000;

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StWrq,
    StWbur,
    StWdone,
    StRrq,
    StRbur,
    StRdone
  } state_e;

endpackage

// File: rtl/sdram_evt_ring.sv
// Event ring bookkeeping: write/read pointers (wrap 65535 -> 0), stored-event count and
// full/empty flags. Advances are ignored when they would over- or under-run the ring.
//   clk, rst_n         clock, asynchronous active-low reset
//   wr_adv, rd_adv     one-cycle pulses: an event was written / consumed
//   wr_ptr, rd_ptr     event indices {bank, row, slot}
//   evt_count          stored events, ring_full / ring_empty derived from it
module sdram_evt_ring
  import sdram_evt_pkg::*;
#(
  parameter logic [EVT_W-1:0] PTR_INIT = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_adv,
  input  logic                 rd_adv,
  output logic [EVT_W-1:0]     wr_ptr,
  output logic [EVT_W-1:0]     rd_ptr,
  output logic [EVT_CNT_W-1:0] evt_count,
  output logic                 ring_full,
  output logic                 ring_empty
);

  logic [EVT_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [EVT_CNT_W-1:0] cnt_q;
  logic                 wr_ok, rd_ok;

  assign ring_full  = (cnt_q == EVT_MAX);
  assign ring_empty = (cnt_q == '0);
  assign wr_ok      = wr_adv && !ring_full;
  assign rd_ok      = rd_adv && !ring_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= PTR_INIT;
      rd_ptr_q <= PTR_INIT;
      cnt_q    <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + EVT_W'(1);
      if (rd_ok) rd_ptr_q <= rd_ptr_q + EVT_W'(1);
      if (wr_ok && !rd_ok)      cnt_q <= cnt_q + EVT_CNT_W'(1);
      else if (rd_ok && !wr_ok) cnt_q <= cnt_q - EVT_CNT_W'(1);
    end
  end

  assign wr_ptr    = wr_ptr_q;
  assign rd_ptr    = rd_ptr_q;
  assign evt_count = cnt_q;

endmodule

// File: rtl/sdram_evt_sched.sv
// Upstream scheduler for the SDRAM controller. Keeps a ring of 256-word events in SDRAM,
// issues one write or read burst at a time (write first), drives the burst address and
// gates the FIFO strobes from the controller ack windows.
//   clk, rst_n                    clock, asynchronous active-low reset
//   sdram_init_done               controller ready; low forces a return to init
//   sdram_wr_ack / sdram_rd_ack   controller data windows, one word per high cycle
//   wfifo_level / rfifo_space     write-FIFO fill, read-FIFO free space
//   evt_rd_en, rd_abort           readout permission, abort of the current read
//   wr_req, rd_req, rd_bstop      controller request / burst-stop
//   sdram_bank/row/col            address of the current burst
//   wfifo_rden, rfifo_wren        FIFO strobes, combinational from the acks
//   evt_count, ring_full/empty    ring occupancy
//   err_flag                      sticky timeout / short-write error
module sdram_evt_sched
  import sdram_evt_pkg::*;
#(
  parameter logic [EVT_W-1:0] PTR_INIT = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sdram_init_done,
  input  logic                 sdram_wr_ack,
  input  logic                 sdram_rd_ack,
  input  logic [LVL_W-1:0]     wfifo_level,
  input  logic [LVL_W-1:0]     rfifo_space,
  input  logic                 evt_rd_en,
  input  logic                 rd_abort,
  output logic                 wr_req,
  output logic                 rd_req,
  output logic                 rd_bstop,
  output logic [BANK_W-1:0]    sdram_bank,
  output logic [ROW_W-1:0]     sdram_row,
  output logic [COL_W-1:0]     sdram_col,
  output logic                 wfifo_rden,
  output logic                 rfifo_wren,
  output logic [EVT_CNT_W-1:0] evt_count,
  output logic                 ring_full,
  output logic                 ring_empty,
  output logic                 err_flag
);

  state_e            state_q, state_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [WCNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic              abort_q, abort_d;
  logic              bstop_q, bstop_d;
  logic              err_q, err_d;
  logic              wr_adv, rd_adv, load_wr, load_rd, aborting;
  logic [EVT_W-1:0]  wr_ptr, rd_ptr, addr_src;

  sdram_evt_ring #(
    .PTR_INIT (PTR_INIT)
  ) u_ring (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_adv     (wr_adv),
    .rd_adv     (rd_adv),
    .wr_ptr     (wr_ptr),
    .rd_ptr     (rd_ptr),
    .evt_count  (evt_count),
    .ring_full  (ring_full),
    .ring_empty (ring_empty)
  );

  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + WCNT_W'(1);
  // Once an abort is seen the rest of the read burst is dropped, including the abort cycle.
  assign aborting = rd_abort || abort_q;

  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    cnt_d      = cnt_q;
    abort_d    = abort_q;
    bstop_d    = 1'b0;
    err_d      = err_q;
    wr_adv     = 1'b0;
    rd_adv     = 1'b0;
    load_wr    = 1'b0;
    load_rd    = 1'b0;
    wr_req     = 1'b0;
    rd_req     = 1'b0;
    wfifo_rden = 1'b0;
    rfifo_wren = 1'b0;

    if ((state_q == StRrq || state_q == StRbur) && rd_abort) begin
      abort_d = 1'b1;
      bstop_d = !abort_q;
    end

    unique case (state_q)
      StInit: begin
        if (sdram_init_done) state_d = StIdle;
      end
      StIdle: begin
        tmo_d   = '0;
        cnt_d   = '0;
        abort_d = 1'b0;
        if (wfifo_level >= LVL_W'(BURST_WORDS) && !ring_full) begin
          state_d = StWrq;
          load_wr = 1'b1;
        end else if (evt_rd_en && !ring_empty && rfifo_space >= LVL_W'(BURST_WORDS)) begin
          state_d = StRrq;
          load_rd = 1'b1;
        end
      end
      StWrq: begin
        wfifo_rden = sdram_wr_ack;
        if (sdram_wr_ack) begin
          cnt_d   = WCNT_W'(1);
          state_d = StWbur;
        end else begin
          wr_req = 1'b1;
          if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
      end
      StWbur: begin
        wfifo_rden = sdram_wr_ack;
        if (sdram_wr_ack) cnt_d = cnt_inc;
        else              state_d = StWdone;
      end
      StWdone: begin
        if (cnt_q != WCNT_W'(BURST_WORDS)) err_d = 1'b1;
        wr_adv  = 1'b1;
        state_d = StIdle;
      end
      StRrq: begin
        rfifo_wren = sdram_rd_ack && !aborting;
        if (sdram_rd_ack) begin
          cnt_d   = WCNT_W'(1);
          state_d = StRbur;
        end else begin
          rd_req = 1'b1;
          if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
      end
      StRbur: begin
        rfifo_wren = sdram_rd_ack && !aborting && (cnt_q < WCNT_W'(BURST_WORDS));
        if (sdram_rd_ack) cnt_d = cnt_inc;
        else              state_d = StRdone;
      end
      StRdone: begin
        rd_adv  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StInit;
    endcase

    // Controller lost init: abandon whatever is in flight, pointers untouched.
    if (!sdram_init_done) state_d = StInit;
  end

  assign addr_src = load_wr ? wr_ptr : rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StInit;
      tmo_q      <= '0;
      cnt_q      <= '0;
      abort_q    <= 1'b0;
      bstop_q    <= 1'b0;
      err_q      <= 1'b0;
      sdram_bank <= '0;
      sdram_row  <= '0;
      sdram_col  <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      bstop_q <= bstop_d;
      err_q   <= err_d;
      if (load_wr || load_rd) begin
        sdram_bank <= addr_src[EVT_W-1 -: BANK_W];
        sdram_row  <= addr_src[ROW_W:1];
        sdram_col  <= {addr_src[0], 8'b0};
      end
    end
  end

  assign rd_bstop = bstop_q;
  assign err_flag = err_q;

endmodule

// File: tb/tb_sdram_evt_sched.sv
// Randomized bench for sdram_evt_sched. A simple controller emulation answers requests with
// ack windows; a ring model (pointer integers, event count, error bit) predicts addresses,
// FIFO strobe counts, occupancy and errors. Pointers start at 65535 so the first write
// exercises the top address and the wrap to 0.
module tb_sdram_evt_sched;
  import sdram_evt_pkg::*;

  localparam logic [15:0] PTR0 = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sdram_init_done, sdram_wr_ack, sdram_rd_ack, evt_rd_en, rd_abort;
  logic [9:0]  wfifo_level, rfifo_space;
  logic        wr_req, rd_req, rd_bstop, wfifo_rden, rfifo_wren;
  logic        ring_full, ring_empty, err_flag;
  logic [1:0]  sdram_bank;
  logic [12:0] sdram_row;
  logic [8:0]  sdram_col;
  logic [16:0] evt_count;

  int total = 0;
  int bad   = 0;
  int m_wr, m_rd, m_cnt;
  bit m_err;

  sdram_evt_sched #(
    .PTR_INIT (PTR0)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sdram_init_done (sdram_init_done),
    .sdram_wr_ack    (sdram_wr_ack),
    .sdram_rd_ack    (sdram_rd_ack),
    .wfifo_level     (wfifo_level),
    .rfifo_space     (rfifo_space),
    .evt_rd_en       (evt_rd_en),
    .rd_abort        (rd_abort),
    .wr_req          (wr_req),
    .rd_req          (rd_req),
    .rd_bstop        (rd_bstop),
    .sdram_bank      (sdram_bank),
    .sdram_row       (sdram_row),
    .sdram_col       (sdram_col),
    .wfifo_rden      (wfifo_rden),
    .rfifo_wren      (rfifo_wren),
    .evt_count       (evt_count),
    .ring_full       (ring_full),
    .ring_empty      (ring_empty),
    .err_flag        (err_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_wr  = PTR0;
    m_rd  = PTR0;
    m_cnt = 0;
    m_err = 0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_wr_req"}, wr_req, 0);
    check({pfx, "_rd_req"}, rd_req, 0);
    check({pfx, "_bstop"}, rd_bstop, 0);
    check({pfx, "_bank"}, sdram_bank, 0);
    check({pfx, "_row"}, sdram_row, 0);
    check({pfx, "_col"}, sdram_col, 0);
    check({pfx, "_rden"}, wfifo_rden, 0);
    check({pfx, "_wren"}, rfifo_wren, 0);
    check({pfx, "_cnt"}, evt_count, 0);
    check({pfx, "_full"}, ring_full, 0);
    check({pfx, "_empty"}, ring_empty, 1);
    check({pfx, "_err"}, err_flag, 0);
  endtask

  task automatic check_state(input string pfx);
    check({pfx, "_cnt"}, evt_count, m_cnt);
    check({pfx, "_empty"}, ring_empty, m_cnt == 0);
    check({pfx, "_full"}, ring_full, m_cnt == 65536);
    check({pfx, "_err"}, err_flag, m_err);
  endtask

  task automatic check_addr(input string pfx, input int ptr);
    check({pfx, "_bank"}, sdram_bank, ptr / 16384);
    check({pfx, "_row"}, sdram_row, (ptr / 2) % 8192);
    check({pfx, "_col"}, sdram_col, (ptr % 2) * 256);
  endtask

  // Wait for the predicted request, answer it with n_ack ack cycles after lat idle cycles,
  // optionally raising rd_abort during ack index abort_at, then check strobes and model.
  task automatic burst(input bit exp_wr, input int lat, input int n_ack, input int abort_at);
    int pushes, stops, exp_push;
    bit seen;
    seen = 0;
    for (int n = 0; n < 64 && !seen; n++) begin
      @(negedge clk);
      seen = wr_req | rd_req;
    end
    check("req_seen", seen, 1);
    if (!seen) return;
    check("req_is_wr", wr_req, exp_wr);
    check("req_is_rd", rd_req, !exp_wr);
    if (exp_wr) wfifo_level = 0;
    else        evt_rd_en = 0;
    check_addr(exp_wr ? "wr_addr" : "rd_addr", exp_wr ? m_wr : m_rd);
    repeat (lat) @(negedge clk);
    pushes = 0;
    stops  = 0;
    for (int i = 0; i < n_ack; i++) begin
      if (exp_wr) sdram_wr_ack = 1;
      else        sdram_rd_ack = 1;
      rd_abort = (i == abort_at);
      #1;
      if (i == 0) check("req_drop_on_ack", exp_wr ? wr_req : rd_req, 0);
      pushes += exp_wr ? int'(wfifo_rden) : int'(rfifo_wren);
      stops  += int'(rd_bstop);
      @(negedge clk);
    end
    sdram_wr_ack = 0;
    sdram_rd_ack = 0;
    rd_abort     = 0;
    repeat (4) begin
      #1;
      stops += int'(rd_bstop);
      @(negedge clk);
    end
    if (exp_wr) begin
      exp_push = n_ack;
      if (n_ack != BURST_WORDS) m_err = 1;
      m_wr = (m_wr + 1) % 65536;
      m_cnt++;
    end else begin
      exp_push = (n_ack > 256) ? 256 : n_ack;
      if (abort_at >= 0 && abort_at < exp_push) exp_push = abort_at;
      m_rd = (m_rd + 1) % 65536;
      m_cnt--;
    end
    check(exp_wr ? "wfifo_pushes" : "rfifo_pushes", pushes, exp_push);
    check("bstop_pulses", stops, (!exp_wr && abort_at >= 0) ? 1 : 0);
    check_state(exp_wr ? "after_wr" : "after_rd");
  endtask

  initial begin
    int n;
    bit seen;
    rst_n = 0; sdram_init_done = 0; sdram_wr_ack = 0; sdram_rd_ack = 0;
    evt_rd_en = 0; rd_abort = 0; wfifo_level = 0; rfifo_space = 0;
    model_reset();
    #2;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    sdram_init_done = 1;

    // Top-of-ring write, then the wrapped write to event 0.
    wfifo_level = 256;
    burst(1, 2, 256, -1);
    wfifo_level = 256;
    burst(1, 0, 256, -1);

    // Write and read demand together: write wins.
    wfifo_level = 300; evt_rd_en = 1; rfifo_space = 300;
    burst(1, 1, 256, -1);
    burst(0, 1, 256, -1);

    // Extra read acks are dropped; abort at word 100.
    evt_rd_en = 1;
    burst(0, 0, 260, -1);
    wfifo_level = 256;
    burst(1, 0, 256, -1);
    evt_rd_en = 1;
    burst(0, 3, 256, 100);

    // Randomized traffic.
    for (int it = 0; it < 12; it++) begin
      if (m_cnt == 0 || $urandom_range(0, 1) == 0) begin
        wfifo_level = 10'(256 + $urandom_range(0, 200));
        burst(1, $urandom_range(0, 4), 256, -1);
      end else begin
        evt_rd_en   = 1;
        rfifo_space = 10'(256 + $urandom_range(0, 300));
        burst(0, $urandom_range(0, 4), 256 + $urandom_range(0, 6),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 255)) : -1);
      end
    end

    // Drain, then an empty ring must not issue reads.
    while (m_cnt > 0) begin
      evt_rd_en = 1; rfifo_space = 256;
      burst(0, 0, 256, -1);
    end
    evt_rd_en = 1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      seen |= rd_req;
    end
    check("no_read_when_empty", seen, 0);
    evt_rd_en = 0;
    rfifo_space = 200;

    // Controller never acks: request must be abandoned.
    wfifo_level = 256;
    seen = 0;
    for (int k = 0; k < 64 && !seen; k++) begin
      @(negedge clk);
      seen = wr_req;
    end
    check("tmo_req_seen", seen, 1);
    n = 0;
    while (wr_req && n < 1100) begin
      n++;
      @(negedge clk);
    end
    wfifo_level = 0;
    check("tmo_req_cycles", n, 1023);
    m_err = 1;
    repeat (3) @(negedge clk);
    check_state("after_tmo");
    wfifo_level = 256;
    burst(1, 0, 256, -1);

    // Reset, short write burst, then reset in the middle of a burst.
    rst_n = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    wfifo_level = 256;
    burst(1, 0, 250, -1);
    wfifo_level = 256;
    seen = 0;
    for (int k = 0; k < 64 && !seen; k++) begin
      @(negedge clk);
      seen = wr_req;
    end
    check("mid_req_seen", seen, 1);
    wfifo_level = 0;
    check_addr("mid_addr", m_wr);
    sdram_wr_ack = 1;
    repeat (50) @(negedge clk);
    #2;
    rst_n = 0;
    #1;
    check_reset_outputs("mid_reset");
    sdram_wr_ack = 0;
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
